// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller timing blocks.
//   TIMER_W        width of the countdown timer value
//   timer_state_t  countdown timer FSM states
//   sat_dec        decrement that holds at zero instead of wrapping
package tlc_pkg;

   localparam int TIMER_W = 4;

   typedef enum logic [1:0] {
      T_IDLE    = 2'd0,
      T_RUN     = 2'd1,
      T_EXPIRED = 2'd2
   } timer_state_t;

   function automatic logic [TIMER_W-1:0] sat_dec(input logic [TIMER_W-1:0] v);
      return (v == '0) ? '0 : v - TIMER_W'(1);
   endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Prescaler producing the shared tick for the traffic light controller.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   clk_en  out  one-cycle tick, high once every DIV clk cycles
// Parameter DIV (2..256) is the number of clk cycles per tick.
module tlc_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic clk_en
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Counter resets to 0 and DIV >= 2, so the tick is low throughout reset
   // and first rises after DIV-1 edges; the DIV-th edge is the first tick edge.
   assign clk_en = (cnt_q == LAST);

endmodule

// File: rtl/tlc_timer.sv
// Countdown timer for the traffic light controller, with its own prescaler.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   clk_en        out  shared tick from the prescaler
//   timer_load    in   load request, sampled on tick cycles only
//   timer_en      in   count-down enable, sampled on tick cycles only
//   timer_init    in   load value 0..15
//   timer_out     out  current count (registered)
//   timer_done    out  high while the timer is expired
//   timer_expire  out  one-clk pulse after the count decrements to 0
//
// state     | meaning
// ----------+-----------------------------------------------------------
// T_IDLE    | no load since reset; count is 0, enable ignored
// T_RUN     | counting down from the last load value
// T_EXPIRED | count is 0 (decremented there or loaded with 0); done high
module tlc_timer
   import tlc_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic               clk,
   input  logic               rst,
   output logic               clk_en,
   input  logic               timer_load,
   input  logic               timer_en,
   input  logic [TIMER_W-1:0] timer_init,
   output logic [TIMER_W-1:0] timer_out,
   output logic               timer_done,
   output logic               timer_expire
);

   timer_state_t       state_q;
   timer_state_t       state_d;
   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;
   logic               done_q;
   logic               done_d;
   logic               expire_q;
   logic               expire_d;

   tlc_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      // Pulse self-clears on the edge after it was set; ticks are never adjacent.
      expire_d = 1'b0;
      if (clk_en) begin
         if (timer_load) begin
            // Load wins over everything, and a reload abandons the old count silently.
            cnt_d   = timer_init;
            state_d = (timer_init != '0) ? T_RUN : T_EXPIRED;
         end else begin
            case (state_q)
               T_IDLE: begin
                  cnt_d = '0;
               end
               T_RUN: begin
                  if (timer_en) begin
                     cnt_d = sat_dec(cnt_q);
                     if (cnt_q == TIMER_W'(1)) begin
                        state_d  = T_EXPIRED;
                        expire_d = 1'b1;
                     end
                  end
               end
               T_EXPIRED: begin
                  cnt_d = '0;
               end
               default: begin
                  state_d = T_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
      done_d = (state_d == T_EXPIRED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= T_IDLE;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         expire_q <= expire_d;
      end
   end

   assign timer_out    = cnt_q;
   assign timer_done   = done_q;
   assign timer_expire = expire_q;

endmodule
